// File: rtl/muldiv_pkg.sv
// Shared definitions for the multiply/divide sequencer.
// Holds the FSM state encoding, the default run lengths and the cycle counter width.
package muldiv_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_MULT_RUN = 3'd1,
    ST_DIV_RUN  = 3'd2,
    ST_WRITE    = 3'd3,
    ST_DZERO    = 3'd4
  } muldiv_state_t;

  localparam int DEF_MULT_CYCLES = 32;
  localparam int DEF_DIV_CYCLES  = 32;
  localparam int CNT_W           = 16;

  // Load value for the cycle counter.
  // A run of n cycles loads n-1 so that the counter reaches zero in the last run cycle.
  function automatic logic [CNT_W-1:0] run_load_value(input int cycles);
    return CNT_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/cycle_counter.sv
// Loadable down-counter that times the multiply and divide run phases.
// The zero flag is decoded from the registered count.
import muldiv_pkg::*;

module cycle_counter (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] value,
  input  logic             enable,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_r;

  // Count register: load has priority over decrement, and the count saturates at zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r <= {CNT_W{1'b0}};
    end else if (load) begin
      cnt_r <= value;
    end else if (enable && (cnt_r != {CNT_W{1'b0}})) begin
      cnt_r <= cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  assign zero = (cnt_r == {CNT_W{1'b0}});

endmodule

// File: rtl/muldiv_sequencer.sv
// Sequences the multiplier and divider runs, and the Hi/Lo write-back that follows each one.
// It sits between control_unit and the multiplier/divider/Hi/Lo muxes. Every output is a register.
import muldiv_pkg::*;

module muldiv_sequencer #(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_mult,
  input  logic        start_div,
  input  logic        abort,
  input  logic [31:0] B_out,
  output logic        MULT_on,
  output logic        DIV_on,
  output logic        Hi_src,
  output logic        Lo_src,
  output logic        Hi_write,
  output logic        Lo_write,
  output logic        busy,
  output logic        done,
  output logic        div_zero
);

  muldiv_state_t    state_r;
  logic             last_op_r;
  logic             b_nonzero_s;
  logic             cnt_load_s;
  logic [CNT_W-1:0] cnt_value_s;
  logic             cnt_enable_s;
  logic             cnt_zero_s;

  assign b_nonzero_s = (B_out != 32'd0);

  // Counter control: load when a run starts from IDLE, decrement in every run cycle.
  always_comb begin
    cnt_load_s   = 1'b0;
    cnt_value_s  = run_load_value(MULT_CYCLES);
    cnt_enable_s = 1'b0;
    if (state_r == ST_IDLE) begin
      if (start_mult) begin
        cnt_load_s  = 1'b1;
        cnt_value_s = run_load_value(MULT_CYCLES);
      end else if (start_div && b_nonzero_s) begin
        cnt_load_s  = 1'b1;
        cnt_value_s = run_load_value(DIV_CYCLES);
      end else begin
        cnt_load_s  = 1'b0;
      end
    end else if ((state_r == ST_MULT_RUN) || (state_r == ST_DIV_RUN)) begin
      cnt_enable_s = 1'b1;
    end else begin
      cnt_enable_s = 1'b0;
    end
  end

  cycle_counter u_cycle_counter (
    .clk    (clk),
    .reset  (reset),
    .load   (cnt_load_s),
    .value  (cnt_value_s),
    .enable (cnt_enable_s),
    .zero   (cnt_zero_s)
  );

  // Sequencer FSM. Each output is registered together with the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      last_op_r <= 1'b0;
      MULT_on   <= 1'b0;
      DIV_on    <= 1'b0;
      Hi_src    <= 1'b0;
      Lo_src    <= 1'b0;
      Hi_write  <= 1'b0;
      Lo_write  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      div_zero  <= 1'b0;
    end else begin
      MULT_on  <= 1'b0;
      DIV_on   <= 1'b0;
      Hi_write <= 1'b0;
      Lo_write <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // Multiply wins a simultaneous request; the divide request is dropped.
          if (start_mult) begin
            state_r   <= ST_MULT_RUN;
            last_op_r <= 1'b1;
            MULT_on   <= 1'b1;
            busy      <= 1'b1;
          end else if (start_div && b_nonzero_s) begin
            state_r   <= ST_DIV_RUN;
            last_op_r <= 1'b0;
            DIV_on    <= 1'b1;
            busy      <= 1'b1;
          end else if (start_div) begin
            state_r  <= ST_DZERO;
            div_zero <= 1'b1;
            busy     <= 1'b1;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_MULT_RUN, ST_DIV_RUN: begin
          if (abort) begin
            state_r <= ST_IDLE;
          end else if (cnt_zero_s) begin
            state_r  <= ST_WRITE;
            Hi_src   <= last_op_r;
            Lo_src   <= last_op_r;
            Hi_write <= 1'b1;
            Lo_write <= 1'b1;
            done     <= 1'b1;
            busy     <= 1'b1;
          end else begin
            state_r <= state_r;
            MULT_on <= (state_r == ST_MULT_RUN);
            DIV_on  <= (state_r == ST_DIV_RUN);
            busy    <= 1'b1;
          end
        end
        ST_WRITE: begin
          state_r <= ST_IDLE;
        end
        ST_DZERO: begin
          state_r <= ST_IDLE;
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 32: number of cycles MULT_on is held for a multiply.
REQ-002 SHALL have parameter DIV_CYCLES, default 32: number of cycles DIV_on is held for a divide.
REQ-003 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  input  1: reset, synchronous and active-high.
REQ-005 SHALL have port start_mult  input  1: control unit requests MULT; sampled only in IDLE.
REQ-006 SHALL have port start_div  input  1: control unit requests DIV; sampled only in IDLE.
REQ-007 SHALL have port abort  input  1: cancels the operation in progress.
REQ-008 SHALL have port B_out  input  32: divisor operand, used only for the divide-by-zero check.
REQ-009 SHALL have port MULT_on  output  1: multiplier run enable.
REQ-010 SHALL have port DIV_on  output  1: divider run enable.
REQ-011 SHALL have port Hi_src  output  1: Hi mux select; 0=divider, 1=multiplier.
REQ-012 SHALL have port Lo_src  output  1: Lo mux select; 0=divider, 1=multiplier.
REQ-013 SHALL have port Hi_write  output  1: Hi register load enable.
REQ-014 SHALL have port Lo_write  output  1: Lo register load enable.
REQ-015 SHALL have port busy  output  1: high in every state except IDLE.
REQ-016 SHALL have port done  output  1: one-cycle pulse when Hi/Lo are written.
REQ-017 SHALL have port div_zero  output  1: one-cycle pulse when a divide is refused for B_out==0.

Function
REQ-018 SHALL implement states IDLE, MULT_RUN, DIV_RUN, WRITE, DZERO.
REQ-019 In IDLE with start_mult=1 at an edge: SHALL enter MULT_RUN and load the counter with MULT_CYCLES-1.
REQ-020 In IDLE with start_div=1, start_mult=0 and B_out!=0: SHALL enter DIV_RUN and load the counter with DIV_CYCLES-1.
REQ-021 In IDLE with start_div=1, start_mult=0 and B_out==0: SHALL enter DZERO.
REQ-022 If start_mult and start_div are both high: multiply SHALL win and the divide request SHALL be dropped.
REQ-023 MULT_on SHALL be high exactly in MULT_RUN, and DIV_on exactly in DIV_RUN, for MULT_CYCLES / DIV_CYCLES consecutive cycles.
REQ-024 Counter SHALL decrement once per RUN cycle; at 0 the FSM SHALL move to WRITE on the next edge.
REQ-025 WRITE SHALL last one cycle with Hi_write=Lo_write=done=1 and Hi_src=Lo_src=1 after a multiply, 0 after a divide; then IDLE.
REQ-026 DZERO SHALL last one cycle with div_zero=1 and Hi_write=Lo_write=0; then IDLE.
REQ-027 Start-to-done latency SHALL be N+1 cycles (default 33): start seen at edge 0, done high in the cycle after edge N.
REQ-028 start_mult/start_div SHALL be ignored while busy=1; they are not queued.
REQ-029 abort=1 in MULT_RUN or DIV_RUN SHALL return to IDLE at the next edge with no Hi/Lo write and no done.
REQ-030 abort SHALL be ignored in IDLE, WRITE and DZERO, and SHALL take priority over counter expiry.
REQ-031 Hi_src/Lo_src SHALL hold their last value outside WRITE, so Hi/Lo mux outputs stay stable.
REQ-032 All outputs SHALL be registered or decoded from the registered state only, with no combinational path from start inputs.

Reset
REQ-033 reset=1 at an edge SHALL force IDLE, counter=0, last-op flag=0, from any state, including mid-RUN.
REQ-034 After reset, all outputs SHALL be 0: MULT_on, DIV_on, Hi_src, Lo_src, Hi_write, Lo_write, busy, done, div_zero.
REQ-035 Reset SHALL win over abort and start in the same cycle.

Structure
REQ-036 The state encoding and the default MULT_CYCLES/DIV_CYCLES constants SHALL live in a shared package muldiv_pkg.
REQ-037 The loadable down-counter SHALL be a sub-module cycle_counter (inputs load, value, enable; output zero flag).
REQ-038 The block SHALL be instantiated between control_unit and the multiplier/divider/Hi/Lo muxes in cpu.

Verification
REQ-039 Multiply: start_mult=1 for 1 cycle -> MULT_on high 32 cycles, then 1 cycle of Hi_write=Lo_write=done=1 with Hi_src=1, then busy=0.
REQ-040 Divide: start_div=1, B_out=7 -> DIV_on high 32 cycles, then done with Hi_src=Lo_src=0.
REQ-041 Divide by zero: start_div=1, B_out=0 -> div_zero=1 for 1 cycle on the next cycle, DIV_on never high, no Hi/Lo write.
REQ-042 Simultaneous requests: start_mult=start_div=1 -> multiply runs; a start_div pulsed during busy is ignored, and only one done occurs.
REQ-043 Abort and reset: abort at RUN cycle 10 -> IDLE next cycle, no done; reset at RUN cycle 20 -> all outputs 0 next cycle.
REQ-044 Back-to-back: start_mult re-asserted in the cycle after done -> new MULT_RUN begins, with latency again 33.
